// File: rtl/cskipa_pkg.sv
// Shared definitions for the 12-bit carry-skip adder datapath.
//
// Contents:
//   CSKIPA_WIDTH      adder operand/sum width
//   CSKIPA_RES_DEPTH  default depth of the result capture FIFO
//   cskipa_res_t      packed result word {cout, sum}; with the macro
//                     CSKIPA_RESULT_PARITY_EN defined, an even-parity bit
//                     'par' sits above cout.
package cskipa_pkg;

  localparam int unsigned CSKIPA_WIDTH     = 12;
  localparam int unsigned CSKIPA_RES_DEPTH = 4;

  typedef struct packed {
`ifdef CSKIPA_RESULT_PARITY_EN
    logic                    par;
`endif
    logic                    cout;
    logic [CSKIPA_WIDTH-1:0] sum;
  } cskipa_res_t;

endpackage

// File: rtl/cskipa_res_mem.sv
// Result storage for cskipa_result_fifo: DEPTH x ENTRY_W register array
// with one synchronous write port and one asynchronous read port.
// Storage is deliberately not reset.
//
// Ports:
//   clk    in   clock, writes on rising edge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational from raddr)
module cskipa_res_mem
  import cskipa_pkg::*;
#(
  parameter int unsigned DEPTH   = CSKIPA_RES_DEPTH,
  parameter int unsigned ENTRY_W = CSKIPA_WIDTH + 1,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cskipa_result_fifo.sv
// Capture stage for the carry-skip adder. Accepts {cout, sum} results
// under valid/ready, buffers them in a circular FIFO and presents them in
// order to a possibly stalling consumer. Keeps a saturating count of
// accepted results with cout=1.
//
// Optional feature macro: CSKIPA_RESULT_PARITY_EN adds an even-parity bit
// per entry and the o_parity_err output.
//
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   i_valid      in   upstream result valid
//   i_sum        in   adder sum
//   i_cout       in   adder carry-out
//   o_ready      out  space available (count < DEPTH)
//   o_valid      out  head entry present (count != 0)
//   o_result     out  head entry {cout, sum}
//   i_ready      in   consumer takes head this cycle
//   i_cnt_clr    in   synchronous clear of carry counter
//   o_carry_cnt  out  saturating count of pushes with cout=1
//   o_count      out  occupancy
//   o_parity_err out  head parity mismatch (macro only)
module cskipa_result_fifo
  import cskipa_pkg::*;
#(
  parameter int unsigned WIDTH = CSKIPA_WIDTH,
  parameter int unsigned DEPTH = CSKIPA_RES_DEPTH,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic [WIDTH-1:0]         i_sum,
  input  logic                     i_cout,
  output logic                     o_ready,
  output logic                     o_valid,
  output logic [WIDTH:0]           o_result,
  input  logic                     i_ready,
  input  logic                     i_cnt_clr,
  output logic [CNT_W-1:0]         o_carry_cnt,
`ifdef CSKIPA_RESULT_PARITY_EN
  output logic                     o_parity_err,
`endif
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
`ifdef CSKIPA_RESULT_PARITY_EN
  localparam int unsigned ENTRY_W = WIDTH + 2;
`else
  localparam int unsigned ENTRY_W = WIDTH + 1;
`endif

  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [CNT_W-1:0]   carry_cnt;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] rdata;

  // Flags come from the occupancy register only, so there is no
  // combinational path from i_valid/i_ready to o_ready/o_valid.
  assign o_ready = (count != CW'(DEPTH));
  assign o_valid = (count != '0);

  assign push = i_valid && o_ready;
  assign pop  = o_valid && i_ready;

`ifdef CSKIPA_RESULT_PARITY_EN
  assign wdata        = {^{i_cout, i_sum}, i_cout, i_sum};
  assign o_parity_err = o_valid && ((^rdata[WIDTH:0]) != rdata[WIDTH+1]);
`else
  assign wdata        = {i_cout, i_sum};
`endif

  assign o_result    = rdata[WIDTH:0];
  assign o_count     = count;
  assign o_carry_cnt = carry_cnt;

  cskipa_res_mem #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_cnt <= '0;
    end else if (i_cnt_clr) begin
      carry_cnt <= '0;
    end else if (push && i_cout && (carry_cnt != '1)) begin
      carry_cnt <= carry_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cskipa_result_fifo.sv
// Self-checking bench for cskipa_result_fifo: directed vector table,
// hand-written multi-cycle sequences, and randomized traffic against a
// queue-based reference model.
module tb_cskipa_result_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [11:0] i_sum = '0;
  logic        i_cout = 1'b0;
  logic        o_ready;
  logic        o_valid;
  logic [12:0] o_result;
  logic        i_ready = 1'b0;
  logic        i_cnt_clr = 1'b0;
  logic [7:0]  o_carry_cnt;
  logic [2:0]  o_count;
`ifdef CSKIPA_RESULT_PARITY_EN
  logic        o_parity_err;
`endif

  int unsigned total = 0;
  int unsigned passed = 0;

  cskipa_result_fifo #(
    .WIDTH (12),
    .DEPTH (4),
    .CNT_W (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .i_sum        (i_sum),
    .i_cout       (i_cout),
    .o_ready      (o_ready),
    .o_valid      (o_valid),
    .o_result     (o_result),
    .i_ready      (i_ready),
    .i_cnt_clr    (i_cnt_clr),
    .o_carry_cnt  (o_carry_cnt),
`ifdef CSKIPA_RESULT_PARITY_EN
    .o_parity_err (o_parity_err),
`endif
    .o_count      (o_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [11:0] sum;
    logic        cout;
    logic        rdy;
    logic        clr;
    logic [2:0]  e_count;
    logic        e_valid;
    logic        e_ready;
    logic [12:0] e_res;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  task automatic step(input logic v, input logic [11:0] sum, input logic cout,
                      input logic rdy, input logic clr);
    i_valid   = v;
    i_sum     = sum;
    i_cout    = cout;
    i_ready   = rdy;
    i_cnt_clr = clr;
    @(posedge clk);
    #1;
  endtask

  logic [12:0] q[$];
  int unsigned mcnt;
  logic        rv, rc, rr, rl;
  logic [11:0] rs;
  logic        mpush, mpop;

  initial begin
    // pre-filled scenarios: single push, fill to full, ignored 5th push,
    // full with push+pop, drain, clear priority, push+pop on 1 entry
    tbl[0]  = '{1'b1, 12'hABC, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 13'h1ABC, 8'd1};
    tbl[1]  = '{1'b1, 12'h001, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 13'h1ABC, 8'd1};
    tbl[2]  = '{1'b1, 12'h002, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 13'h1ABC, 8'd2};
    tbl[3]  = '{1'b1, 12'h003, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 13'h1ABC, 8'd2};
    tbl[4]  = '{1'b1, 12'h0FF, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 13'h1ABC, 8'd2};
    tbl[5]  = '{1'b1, 12'h0FF, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 13'h0001, 8'd2};
    tbl[6]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 13'h1002, 8'd2};
    tbl[7]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 13'h0003, 8'd2};
    tbl[8]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 13'h0000, 8'd2};
    tbl[9]  = '{1'b1, 12'h7FF, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 13'h17FF, 8'd0};
    tbl[10] = '{1'b1, 12'h123, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 13'h1123, 8'd1};
    tbl[11] = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 13'h1123, 8'd0};

    #12;
    rst = 1'b0;
    #1;
    chk("reset_count", 32'(o_count), 32'd0);
    chk("reset_valid", 32'(o_valid), 32'd0);
    chk("reset_ready", 32'(o_ready), 32'd1);
    chk("reset_carry", 32'(o_carry_cnt), 32'd0);

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, tbl[i].sum, tbl[i].cout, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("vec%0d_count", i), 32'(o_count), 32'(tbl[i].e_count));
      chk($sformatf("vec%0d_valid", i), 32'(o_valid), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d_ready", i), 32'(o_ready), 32'(tbl[i].e_ready));
      chk($sformatf("vec%0d_carry", i), 32'(o_carry_cnt), 32'(tbl[i].e_cnt));
      if (tbl[i].e_valid) begin
        chk($sformatf("vec%0d_result", i), 32'(o_result), 32'(tbl[i].e_res));
      end
    end

    // streaming push+pop across several pointer wraps
    step(1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
    chk("stream_empty", 32'(o_count), 32'd0);
    step(1'b1, 12'h000, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 12'(i), 1'b0, 1'b1, 1'b0);
      chk($sformatf("stream%0d_result", i), 32'(o_result), 32'(i));
      chk($sformatf("stream%0d_count", i), 32'(o_count), 32'd1);
    end

    // carry counter saturation, then clear beating a cout push
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 12'(i), 1'b1, 1'b1, 1'b0);
    end
    chk("carry_saturate", 32'(o_carry_cnt), 32'd255);
    step(1'b1, 12'h055, 1'b1, 1'b1, 1'b1);
    chk("carry_clr_prio", 32'(o_carry_cnt), 32'd0);
    step(1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
    chk("drain_count", 32'(o_count), 32'd0);

    // asynchronous reset with entries buffered
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 12'(12'h100 + i), 1'b0, 1'b0, 1'b0);
    end
    chk("pre_rst_count", 32'(o_count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(o_valid), 32'd0);
    chk("async_rst_count", 32'(o_count), 32'd0);
    chk("async_rst_ready", 32'(o_ready), 32'd1);
    #3;
    rst = 1'b0;
    step(1'b1, 12'h005, 1'b0, 1'b0, 1'b0);
    chk("post_rst_valid", 32'(o_valid), 32'd1);
    chk("post_rst_result", 32'(o_result), 32'h005);

    // randomized traffic against a queue model
    #2;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    q.delete();
    mcnt = 0;
    for (int i = 0; i < 1500; i++) begin
      rv = ($urandom_range(0, 9) < 7);
      rr = ($urandom_range(0, 9) < 6);
      rl = ($urandom_range(0, 49) == 0);
      rc = 1'($urandom_range(0, 1));
      rs = 12'($urandom);
      mpush = rv && (q.size() < 4);
      mpop  = rr && (q.size() > 0);
      step(rv, rs, rc, rr, rl);
      if (mpop) void'(q.pop_front());
      if (mpush) q.push_back({rc, rs});
      if (rl) mcnt = 0;
      else if (mpush && rc && mcnt < 255) mcnt++;
      chk("rand_count", 32'(o_count), 32'(q.size()));
      chk("rand_valid", 32'(o_valid), 32'(q.size() != 0));
      chk("rand_ready", 32'(o_ready), 32'(q.size() < 4));
      chk("rand_carry", 32'(o_carry_cnt), 32'(mcnt));
      if (q.size() != 0) begin
        chk("rand_result", 32'(o_result), 32'(q[0]));
`ifdef CSKIPA_RESULT_PARITY_EN
        chk("rand_parity", 32'(o_parity_err), 32'd0);
`endif
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cskipa_result_fifo.md
# cskipa_result_fifo

Downstream capture stage for the 12-bit carry-skip adder. It accepts each combinational `{cout, sum}` result under a valid/ready handshake and buffers it in a small circular FIFO. It presents the results in order to the consumer and keeps a saturating count of carry-out events. It decouples the single-cycle adder from a consumer that may stall.

## Interface
Parameters:
- `WIDTH`, 12, adder operand/sum width; result word is `WIDTH+1` bits.
- `DEPTH`, 4, FIFO entries; power of two, 2..16.
- `CNT_W`, 8, width of carry-event counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_valid`  in  1  upstream adder result valid.
- `i_sum`  in  WIDTH  adder `sum`.
- `i_cout`  in  1  adder `cout`.
- `o_ready`  out  1  stage can accept; `count < DEPTH`.
- `o_valid`  out  1  head entry present; `count != 0`.
- `o_result`  out  WIDTH+1  head entry, `{cout, sum}`.
- `i_ready`  in  1  consumer accepts head this cycle.
- `i_cnt_clr`  in  1  synchronous clear of carry counter.
- `o_carry_cnt`  out  CNT_W  number of accepted entries with cout=1, saturating.
- `o_count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Push when `i_valid && o_ready`. Write `{i_cout, i_sum}` at `wr_ptr`, then increment `wr_ptr`.
- Pop when `o_valid && i_ready`. Increment `rd_ptr`.
- `o_result` is the storage word at `rd_ptr`. Its value is don't-care when `o_valid=0`.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally from DEPTH-1 to 0.
- Occupancy update: push only +1; pop only -1; push and pop together leaves it unchanged.
- Full: `o_ready=0`. There is no pass-through, so a pop while full frees space only for the next cycle.
- Empty: `o_valid=0`. A push into an empty FIFO is not visible in the same cycle.
- Carry counter:
  - Increments on each push with `i_cout=1` and saturates at 2^CNT_W-1.
  - `i_cnt_clr` has priority over increment; the counter becomes 0 that cycle.
- Data ordering is strictly FIFO; no entry is dropped or duplicated.
- Reset mid-operation discards all buffered entries immediately, asynchronously.

## Timing
- Reset values:
  - `o_valid=0`, `o_count=0`, `o_carry_cnt=0`, `o_ready=1`.
  - Pointers are 0. Storage is not reset.
- Latency: a result pushed at edge N has `o_valid=1` from edge N to N+1 onward; minimum 1 cycle.
- Throughput: one push and one pop per cycle sustained when not full.
- `o_ready`, `o_valid`, `o_count` and `o_result` are decoded from registers only; there is no combinational path from `i_valid`/`i_ready`.
- Upstream rule: `i_sum`/`i_cout` are sampled only on the push edge. Upstream may drop `i_valid` at any time.
- Consumer rule: once `o_valid=1`, `o_result` stays stable until the pop edge.

## Configuration
- `CSKIPA_RESULT_PARITY_EN`
  - Defined: each entry stores an extra even-parity bit computed over `{i_cout, i_sum}` at push. A port `o_parity_err` (out, 1) asserts combinationally while `o_valid=1` and the head's recomputed parity mismatches the stored bit. Storage is WIDTH+2 bits.
  - Undefined: the parity bit and the `o_parity_err` port are absent. Storage is WIDTH+1 bits.

## Structure
- Shared package `cskipa_pkg` holds:
  - `CSKIPA_WIDTH=12` and `CSKIPA_RES_DEPTH=4`.
  - Typedef `cskipa_res_t` (packed `{cout, sum}`, plus `par` under the macro).
- One sub-module, `cskipa_res_mem`: a DEPTH x entry register array with one write port and one asynchronous read port. The top level holds the pointers, occupancy, handshake and counter.

## Test plan
- Reset then single push `sum=0xABC, cout=1`, `i_ready=0` -> next cycle `o_valid=1`, `o_result=0x1ABC`, `o_carry_cnt=1`, `o_count=1`.
- Push 4 entries with `i_ready=0` -> `o_ready=0` after the 4th. A 5th `i_valid` is ignored. Draining yields the 4 entries in order.
- Full FIFO, simultaneous `i_valid=1, i_ready=1` -> one pop and no push that cycle. Next cycle `o_count=3`, `o_ready=1`.
- Continuous push and pop for 20 cycles with incrementing sums -> outputs match the input sequence across pointer wrap, with `o_count` steady at 1.
- Push 300 results with `cout=1` -> `o_carry_cnt` saturates at 255. `i_cnt_clr` together with a cout push -> counter reads 0.
- Assert `rst` with 3 entries buffered -> `o_valid=0` and `o_count=0` immediately without a clock edge. Post-reset push of 0x005 is the first output.
